cb_op_sequencer: RTL and testbench

Sequences execution of CB-prefixed opcodes (rotate/shift/swap, BIT, RES, SET) on the combinational bit-operation unit. It decodes the CB opcode, fetches the operand from the register file or from memory at (HL), drives the bit-op unit, and writes back the result and flags. It sits between the CPU decode/control FSM and the register file / memory bus, and raises done when the instruction is complete.

---
 rtl/cb_op_sequencer.sv | 247 ++++++++++++++++++++++++
 tb/tb_cb_op_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cb_op_sequencer.sv
// CB-prefix opcode sequencer: operand fetch, bit-op unit drive, register/memory write-back, flag update.
// Optional macro CB_TIMING_PAD_EN stretches completion to fixed per-class cycle counts.
//
// state  | meaning
// IDLE   | waiting for start, inputs latched on start
// RREAD  | capture register operand
// MRD    | memory read of (HL), wait for mem_ack
// EXEC   | capture bit-op result and flags
// RWB    | register write-back strobe
// MWR    | memory write of (HL), wait for mem_ack
// PAD    | completion held back until the pad counter expires
// DONE   | done pulse and flag write strobe

module cb_op_sequencer #(
    parameter int PAD_REG    = 8,
    parameter int PAD_HL_BIT = 12,
    parameter int PAD_HL_RMW = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  opcode,
    input  logic [3:0]  flags_in,
    input  logic [15:0] hl_addr,
    output logic        busy,
    output logic        done,
    output logic [4:0]  alu_op,
    output logic [7:0]  alu_in,
    output logic        alu_c_in,
    input  logic [7:0]  alu_out,
    input  logic        alu_c,
    input  logic        alu_z,
    input  logic        alu_h,
    output logic [2:0]  reg_rd_idx,
    input  logic [7:0]  reg_rd_data,
    output logic        reg_wr_en,
    output logic [2:0]  reg_wr_idx,
    output logic [7:0]  reg_wr_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        flags_wr_en,
    output logic [3:0]  flags_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RREAD,
        S_MRD,
        S_EXEC,
        S_RWB,
        S_MWR,
        S_PAD,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [7:0]  r_opcode;
    logic        r_carry;
    logic [15:0] r_addr;
    logic [7:0]  r_operand;
    logic [7:0]  r_result;
    logic [3:0]  r_flags;
    logic        r_done;
    logic        r_flags_wr_en;
    logic        r_reg_wr_en;
    logic        r_mem_req;
    logic        r_mem_we;

    logic        w_is_hl;
    logic        w_is_rot;
    logic        w_is_bit;
    logic        w_flags_class;
    logic        w_pad_ok;
    logic        w_unused;

    assign w_is_hl       = (r_opcode[2:0] == 3'd6);
    assign w_is_rot      = (r_opcode[7:6] == 2'b00);
    assign w_is_bit      = (r_opcode[7:6] == 2'b01);
    assign w_flags_class = ~r_opcode[7];

    // The bit-op unit's half-carry is never needed: H is constant per op class.
    assign w_unused = alu_h;

`ifdef CB_TIMING_PAD_EN
    logic [7:0] r_pad_cnt;

    // Remaining cycles until the earliest allowed DONE cycle, loaded at T0.
    function automatic logic [7:0] pad_load(input logic [7:0] op);
        if (op[2:0] != 3'd6)
            return 8'(PAD_REG - 1);
        else if (op[7:6] == 2'b01)
            return 8'(PAD_HL_BIT - 1);
        else
            return 8'(PAD_HL_RMW - 1);
    endfunction

    assign w_pad_ok = (r_pad_cnt <= 8'd1);
`else
    logic [31:0] w_unused_pad;

    assign w_unused_pad = 32'(PAD_REG + PAD_HL_BIT + PAD_HL_RMW);
    assign w_pad_ok     = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_opcode      <= 8'h00;
            r_carry       <= 1'b0;
            r_addr        <= 16'h0000;
            r_operand     <= 8'h00;
            r_result      <= 8'h00;
            r_flags       <= 4'h0;
            r_done        <= 1'b0;
            r_flags_wr_en <= 1'b0;
            r_reg_wr_en   <= 1'b0;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
`ifdef CB_TIMING_PAD_EN
            r_pad_cnt     <= 8'd0;
`endif
        end else begin
            r_done        <= 1'b0;
            r_flags_wr_en <= 1'b0;
            r_reg_wr_en   <= 1'b0;
`ifdef CB_TIMING_PAD_EN
            if (r_pad_cnt != 8'd0)
                r_pad_cnt <= r_pad_cnt - 8'd1;
`endif
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_opcode <= opcode;
                        r_carry  <= flags_in[0];
                        r_flags  <= flags_in;
                        r_addr   <= hl_addr;
`ifdef CB_TIMING_PAD_EN
                        r_pad_cnt <= pad_load(opcode);
`endif
                        if (opcode[2:0] == 3'd6) begin
                            r_state   <= S_MRD;
                            r_mem_req <= 1'b1;
                            r_mem_we  <= 1'b0;
                        end else begin
                            r_state <= S_RREAD;
                        end
                    end
                end
                S_RREAD: begin
                    r_operand <= reg_rd_data;
                    r_state   <= S_EXEC;
                end
                S_MRD: begin
                    if (mem_ack) begin
                        r_operand <= mem_rdata;
                        r_mem_req <= 1'b0;
                        r_state   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_result <= alu_out;
                    if (w_is_rot)
                        r_flags <= {alu_z, 1'b0, 1'b0, alu_c};
                    else if (w_is_bit)
                        r_flags <= {alu_z, 1'b0, 1'b1, r_carry};

                    if (w_is_bit) begin
                        if (w_pad_ok) begin
                            r_state       <= S_DONE;
                            r_done        <= 1'b1;
                            r_flags_wr_en <= 1'b1;
                        end else begin
                            r_state <= S_PAD;
                        end
                    end else if (w_is_hl) begin
                        r_state   <= S_MWR;
                        r_mem_req <= 1'b1;
                        r_mem_we  <= 1'b1;
                    end else begin
                        r_state     <= S_RWB;
                        r_reg_wr_en <= 1'b1;
                    end
                end
                S_RWB: begin
                    if (w_pad_ok) begin
                        r_state       <= S_DONE;
                        r_done        <= 1'b1;
                        r_flags_wr_en <= w_flags_class;
                    end else begin
                        r_state <= S_PAD;
                    end
                end
                S_MWR: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        if (w_pad_ok) begin
                            r_state       <= S_DONE;
                            r_done        <= 1'b1;
                            r_flags_wr_en <= w_flags_class;
                        end else begin
                            r_state <= S_PAD;
                        end
                    end
                end
                S_PAD: begin
                    if (w_pad_ok) begin
                        r_state       <= S_DONE;
                        r_done        <= 1'b1;
                        r_flags_wr_en <= w_flags_class;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Group 00 selects the rotate/shift/swap variant with opcode[5:3]; other groups carry their class bits.
    assign alu_op      = {r_opcode[7:6], r_opcode[5:3]};
    assign alu_in      = r_operand;
    assign alu_c_in    = r_carry;

    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign flags_wr_en = r_flags_wr_en;
    assign flags_out   = r_flags;

    assign reg_rd_idx  = r_opcode[2:0];
    assign reg_wr_en   = r_reg_wr_en;
    assign reg_wr_idx  = r_opcode[2:0];
    assign reg_wr_data = r_result;

    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_addr;
    assign mem_wdata   = r_result;

endmodule

// File: tb/tb_cb_op_sequencer.sv
// Bench for cb_op_sequencer: register file, memory responder and bit-op unit models around the DUT,
// a vector table of CB ops plus hand-written reset and busy-start sequences.

module tb_cb_op_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  opcode = 8'h00;
    logic [3:0]  flags_in = 4'h0;
    logic [15:0] hl_addr = 16'h0000;
    logic        busy, done;
    logic [4:0]  alu_op;
    logic [7:0]  alu_in;
    logic        alu_c_in;
    logic [7:0]  alu_out;
    logic        alu_c, alu_z, alu_h;
    logic [2:0]  reg_rd_idx;
    logic [7:0]  reg_rd_data;
    logic        reg_wr_en;
    logic [2:0]  reg_wr_idx;
    logic [7:0]  reg_wr_data;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_ack = 1'b0;
    logic        flags_wr_en;
    logic [3:0]  flags_out;

    cb_op_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
        .flags_in(flags_in), .hl_addr(hl_addr), .busy(busy), .done(done),
        .alu_op(alu_op), .alu_in(alu_in), .alu_c_in(alu_c_in),
        .alu_out(alu_out), .alu_c(alu_c), .alu_z(alu_z), .alu_h(alu_h),
        .reg_rd_idx(reg_rd_idx), .reg_rd_data(reg_rd_data),
        .reg_wr_en(reg_wr_en), .reg_wr_idx(reg_wr_idx), .reg_wr_data(reg_wr_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .flags_wr_en(flags_wr_en), .flags_out(flags_out)
    );

    always #5 clk = ~clk;

    logic [7:0] regs [8];
    assign reg_rd_data = regs[reg_rd_idx];

    // Reference bit-op unit.
    always_comb begin
        alu_out = alu_in;
        alu_c   = alu_c_in;
        alu_h   = 1'b0;
        case (alu_op[4:3])
            2'b00: begin
                case (alu_op[2:0])
                    3'd0: begin alu_out = {alu_in[6:0], alu_in[7]}; alu_c = alu_in[7]; end
                    3'd1: begin alu_out = {alu_in[0], alu_in[7:1]}; alu_c = alu_in[0]; end
                    3'd2: begin alu_out = {alu_in[6:0], alu_c_in};  alu_c = alu_in[7]; end
                    3'd3: begin alu_out = {alu_c_in, alu_in[7:1]};  alu_c = alu_in[0]; end
                    3'd4: begin alu_out = {alu_in[6:0], 1'b0};      alu_c = alu_in[7]; end
                    3'd5: begin alu_out = {alu_in[7], alu_in[7:1]}; alu_c = alu_in[0]; end
                    3'd6: begin alu_out = {alu_in[3:0], alu_in[7:4]}; alu_c = 1'b0; end
                    default: begin alu_out = {1'b0, alu_in[7:1]}; alu_c = alu_in[0]; end
                endcase
            end
            2'b01: alu_h = 1'b1;
            2'b10: alu_out = alu_in & ~(8'h01 << alu_op[2:0]);
            default: alu_out = alu_in | (8'h01 << alu_op[2:0]);
        endcase
        alu_z = (alu_op[4:3] == 2'b01) ? ~alu_in[alu_op[2:0]] : (alu_out == 8'h00);
    end

    // Memory responder: acks each request after ack_delay wait cycles.
    int          ack_delay = 0;
    logic [7:0]  mem_val = 8'h00;
    int          rd_cnt = 0, wr_cnt = 0;
    logic [15:0] rd_addr = 16'h0, wr_addr = 16'h0;
    logic [7:0]  wr_data = 8'h0;

    initial begin
        int wcnt;
        wcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_ack || !mem_req) begin
                mem_ack = 1'b0;
                wcnt    = 0;
            end else if (wcnt == ack_delay) begin
                mem_ack = 1'b1;
                if (mem_we) begin
                    wr_cnt++;
                    wr_addr = mem_addr;
                    wr_data = mem_wdata;
                end else begin
                    rd_cnt++;
                    rd_addr   = mem_addr;
                    mem_rdata = mem_val;
                end
            end else begin
                wcnt++;
            end
        end
    end

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp)
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        else
            n_pass++;
    endtask

    typedef struct {
        string       name;
        logic [7:0]  op;
        logic [3:0]  fin;
        logic [15:0] hl;
        logic [7:0]  rval;
        logic [7:0]  mval;
        int          dly;
        int          nat;
        logic        rwe;
        logic [7:0]  data;
        logic        fwe;
        logic [3:0]  flags;
        logic        mwr;
        logic        ms;
    } vec_t;

    function automatic int exp_done(input vec_t v);
        int t;
        t = v.nat;
`ifdef CB_TIMING_PAD_EN
        begin
            int pad;
            if (v.op[2:0] != 3'd6)      pad = 8;
            else if (v.op[7:6] == 2'b01) pad = 12;
            else                        pad = 16;
            if (pad > t) t = pad;
        end
`endif
        return t;
    endfunction

    task automatic run_and_check(input vec_t v);
        int         done_cyc, rwe_cnt;
        logic [2:0] ridx;
        logic [7:0] rdata;
        logic       fwe;
        logic [3:0] fl;
        done_cyc = -1; rwe_cnt = 0; ridx = 3'd0; rdata = 8'h00; fwe = 1'b0; fl = 4'h0;
        regs[v.op[2:0]] = v.rval;
        mem_val = v.mval; ack_delay = v.dly;
        rd_cnt = 0; wr_cnt = 0;
        opcode = v.op; flags_in = v.fin; hl_addr = v.hl; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; opcode = 8'hFF; flags_in = ~v.fin; hl_addr = ~v.hl;
        for (int k = 1; k <= 60; k++) begin
            if (v.ms && k == 2) start = 1'b1;
            if (v.ms && k == 3) start = 1'b0;
            if (reg_wr_en) begin
                rwe_cnt++;
                ridx  = reg_wr_idx;
                rdata = reg_wr_data;
            end
            if (done) begin
                done_cyc = k;
                fwe = flags_wr_en;
                fl  = flags_out;
                break;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        chk({v.name, " done_cycle"}, 32'(done_cyc), 32'(exp_done(v)));
        chk({v.name, " reg_wr_count"}, 32'(rwe_cnt), 32'(v.rwe));
        if (v.rwe) begin
            chk({v.name, " reg_wr_idx"}, 32'(ridx), 32'(v.op[2:0]));
            chk({v.name, " reg_wr_data"}, 32'(rdata), 32'(v.data));
        end
        chk({v.name, " flags_wr_en"}, 32'(fwe), 32'(v.fwe));
        if (v.fwe)
            chk({v.name, " flags_out"}, 32'(fl), 32'(v.flags));
        chk({v.name, " mem_wr_count"}, 32'(wr_cnt), 32'(v.mwr));
        if (v.mwr) begin
            chk({v.name, " mem_wr_addr"}, 32'(wr_addr), 32'(v.hl));
            chk({v.name, " mem_wr_data"}, 32'(wr_data), 32'(v.data));
        end
        if (v.op[2:0] == 3'd6) begin
            chk({v.name, " mem_rd_count"}, 32'(rd_cnt), 32'd1);
            chk({v.name, " mem_rd_addr"}, 32'(rd_addr), 32'(v.hl));
        end
        @(posedge clk);
        #1;
        chk({v.name, " busy_after_done"}, 32'(busy), 32'd0);
        chk({v.name, " done_after_done"}, 32'(done), 32'd0);
    endtask

    vec_t vecs [9];

    initial begin
        bit found;
        bit saw_done;

        vecs[0] = '{"RLC B",      8'h00, 4'h0, 16'h0000, 8'h85, 8'h00, 0,  4,  1'b1, 8'h0B, 1'b1, 4'b0001, 1'b0, 1'b0};
        vecs[1] = '{"BIT 7,H",    8'h7C, 4'h1, 16'h0000, 8'h00, 8'h00, 0,  3,  1'b0, 8'h00, 1'b1, 4'b1011, 1'b0, 1'b0};
        vecs[2] = '{"SET 3,(HL)", 8'hDE, 4'h0, 16'hC000, 8'h00, 8'h00, 2,  8,  1'b0, 8'h08, 1'b0, 4'b0000, 1'b1, 1'b0};
        vecs[3] = '{"SWAP A",     8'h37, 4'h0, 16'h0000, 8'h00, 8'h00, 0,  4,  1'b1, 8'h00, 1'b1, 4'b1000, 1'b0, 1'b1};
        vecs[4] = '{"RES 0,C",    8'h81, 4'hF, 16'h0000, 8'hFF, 8'h00, 0,  4,  1'b1, 8'hFE, 1'b0, 4'b0000, 1'b0, 1'b0};
        vecs[5] = '{"SLA D",      8'h22, 4'h6, 16'h0000, 8'h80, 8'h00, 0,  4,  1'b1, 8'h00, 1'b1, 4'b1001, 1'b0, 1'b0};
        vecs[6] = '{"BIT 0,(HL)", 8'h46, 4'h1, 16'h1234, 8'h00, 8'h01, 0,  3,  1'b0, 8'h00, 1'b1, 4'b0011, 1'b0, 1'b0};
        vecs[7] = '{"RLC (HL)",   8'h06, 4'h0, 16'hABCD, 8'h00, 8'h80, 10, 24, 1'b0, 8'h01, 1'b1, 4'b0001, 1'b1, 1'b0};
        vecs[8] = '{"RL E",       8'h13, 4'h1, 16'h0000, 8'h40, 8'h00, 0,  4,  1'b1, 8'h81, 1'b1, 4'b0000, 1'b0, 1'b0};

        for (int i = 0; i < 8; i++) regs[i] = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset mem_req", 32'(mem_req), 32'd0);
        chk("reset reg_wr_en", 32'(reg_wr_en), 32'd0);
        chk("reset flags_wr_en", 32'(flags_wr_en), 32'd0);
        chk("reset alu_op", 32'(alu_op), 32'd0);
        chk("reset flags_out", 32'(flags_out), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++)
            run_and_check(vecs[i]);

        // RR (HL) interrupted by reset while the write-back request is outstanding.
        mem_val = 8'h01; ack_delay = 3; wr_cnt = 0;
        opcode = 8'h1E; flags_in = 4'h1; hl_addr = 16'h8000; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        found = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (mem_req && mem_we) begin
                found = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("rst reached MWR", 32'(found), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst mem_req dropped", 32'(mem_req), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst alu_in cleared", 32'(alu_in), 32'd0);
        saw_done = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        chk("rst no done", 32'(saw_done), 32'd0);
        chk("rst no mem write", 32'(wr_cnt), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_and_check(vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
